// File: rtl/vdic_serial_rx_if.sv
// Packet output bus of the VDIC serial receiver.
// The receiver drives the master side and the DUT core consumes through the slave side.
//
// Handshake: a packet is transferred on a rising edge where pkt_valid && pkt_ready.
// While pkt_valid is high and pkt_ready is low, the producer holds pkt_valid and all fields stable.
// The one exception is an overrun: the serial side cannot stall, so a newer packet
// replaces the held one and flags err[3].
// pkt_ready has no effect while pkt_valid is low.
interface vdic_serial_rx_if #(
  parameter int MAX_BYTES = 8,
  parameter int SIZE_W    = 4
);
  logic                   pkt_valid;
  logic                   pkt_ready;
  logic [7:0]             pkt_cmd;
  logic [SIZE_W-1:0]      pkt_size;
  logic [8*MAX_BYTES-1:0] pkt_data;
  logic [3:0]             pkt_err;

  modport master (
    output pkt_valid,
    output pkt_cmd,
    output pkt_size,
    output pkt_data,
    output pkt_err,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid,
    input  pkt_cmd,
    input  pkt_size,
    input  pkt_data,
    input  pkt_err,
    output pkt_ready
  );
endinterface

// File: rtl/vdic_serial_rx.sv
// vdic_serial_rx: deserializes 10-bit frames (flag, d7..d0, parity) arriving on enable_n/din.
// It assembles data bytes, terminated by a command word, into one parallel packet.
// The packet is offered on the vdic_serial_rx_if bus, together with the
// parity/overflow/framing/overrun error flags.
// Optional build macro VDIC_RX_STATS_EN adds saturating packet and error counters.
module vdic_serial_rx #(
  parameter int MAX_BYTES = 8,
  parameter int SIZE_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_n,
  input  logic                    din,
`ifdef VDIC_RX_STATS_EN
  output logic [15:0]             stat_pkt_cnt,
  output logic [7:0]              stat_err_cnt,
`endif
  vdic_serial_rx_if.master        pkt,
  output logic                    busy,
  output logic                    dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RX   = 1'b1
  } state_t;

  localparam logic [SIZE_W-1:0] MAX_CNT = SIZE_W'(MAX_BYTES);

  // receive-side state
  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [SIZE_W-1:0]      byte_cnt_q, byte_cnt_d;
  // Holds the first nine bits of a word (flag..d0).
  // The parity bit is taken straight from din.
  logic [8:0]             shreg_q, shreg_d;
  logic [8*MAX_BYTES-1:0] data_q, data_d;
  // [0] parity, [1] overflow, collected while the packet is assembled
  logic [1:0]             asm_err_q, asm_err_d;

  // output registers
  logic                   valid_q, valid_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [SIZE_W-1:0]      size_q, size_d;
  logic [8*MAX_BYTES-1:0] odata_q, odata_d;
  logic [3:0]             err_q, err_d;

  logic [9:0]             word;
  logic                   parity_bad;
  logic                   overrun;
  logic                   emit;

  // Next-state logic: bit/word sequencing, packet assembly and output loading
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    asm_err_d  = asm_err_q;
    valid_d    = valid_q;
    cmd_d      = cmd_q;
    size_d     = size_q;
    odata_d    = odata_q;
    err_d      = err_q;
    emit       = 1'b0;

    word       = {shreg_q, din};
    parity_bad = word[0] ^ (^word[8:1]);
    // A packet landing now replaces one the consumer has not taken.
    overrun    = valid_q & ~pkt.pkt_ready;

    if (valid_q && pkt.pkt_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!enable_n) begin
          shreg_d   = {8'h00, din};
          bit_cnt_d = 4'd1;
          state_d   = RX;
        end
      end

      RX: begin
        if (!enable_n) begin
          shreg_d = {shreg_q[7:0], din};
          if (bit_cnt_q == 4'd9) begin
            bit_cnt_d = 4'd0;
            if (word[9]) begin
              // Command word closes the packet.
              // Stay in RX so a following bit starts the next packet.
              emit       = 1'b1;
              cmd_d      = word[8:1];
              size_d     = byte_cnt_q;
              odata_d    = data_q;
              err_d      = {overrun, 1'b0, asm_err_q[1], asm_err_q[0] | parity_bad};
              byte_cnt_d = '0;
              data_d     = '0;
              asm_err_d  = '0;
            end else begin
              asm_err_d[0] = asm_err_q[0] | parity_bad;
              if (byte_cnt_q < MAX_CNT) begin
                for (int i = 0; i < MAX_BYTES; i++) begin
                  if (byte_cnt_q == SIZE_W'(i)) begin
                    data_d[8*i +: 8] = word[8:1];
                  end
                end
                byte_cnt_d = byte_cnt_q + 1'b1;
              end else begin
                asm_err_d[1] = 1'b1;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          // enable_n released before a command word arrived.
          // If nothing at all was received for this packet, drop back silently.
          state_d = IDLE;
          bit_cnt_d = 4'd0;
          if ((bit_cnt_q != 4'd0) || (byte_cnt_q != '0)) begin
            emit    = 1'b1;
            cmd_d   = 8'h00;
            size_d  = byte_cnt_q;
            odata_d = data_q;
            err_d   = {overrun, 1'b1, asm_err_q};
          end
          byte_cnt_d = '0;
          data_d     = '0;
          asm_err_d  = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    if (emit) begin
      valid_d = 1'b1;
    end
  end

  // State and data registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      asm_err_q  <= '0;
      valid_q    <= 1'b0;
      cmd_q      <= 8'h00;
      size_q     <= '0;
      odata_q    <= '0;
      err_q      <= 4'h0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      asm_err_q  <= asm_err_d;
      valid_q    <= valid_d;
      cmd_q      <= cmd_d;
      size_q     <= size_d;
      odata_q    <= odata_d;
      err_q      <= err_d;
    end
  end

  assign pkt.pkt_valid = valid_q;
  assign pkt.pkt_cmd   = cmd_q;
  assign pkt.pkt_size  = size_q;
  assign pkt.pkt_data  = odata_q;
  assign pkt.pkt_err   = err_q;
  assign busy          = (state_q == RX);
  assign dbg_state     = state_q;

`ifdef VDIC_RX_STATS_EN
  logic [15:0] stat_pkt_q, stat_pkt_d;
  logic [7:0]  stat_err_q, stat_err_d;

  // Saturating counters of emitted packets and of emissions carrying any error
  always_comb begin
    stat_pkt_d = stat_pkt_q;
    stat_err_d = stat_err_q;
    if (emit && (stat_pkt_q != 16'hFFFF)) begin
      stat_pkt_d = stat_pkt_q + 16'd1;
    end
    if (emit && (err_d != 4'h0) && (stat_err_q != 8'hFF)) begin
      stat_err_d = stat_err_q + 8'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkt_q <= 16'd0;
      stat_err_q <= 8'd0;
    end else begin
      stat_pkt_q <= stat_pkt_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_pkt_cnt = stat_pkt_q;
  assign stat_err_cnt = stat_err_q;
`endif

endmodule

// File: tb/tb_vdic_serial_rx.sv
// Testbench for vdic_serial_rx.
// Directed frames are driven on enable_n/din, and the expected packets go into exp_q.
// A monitor pops and compares whenever a packet is accepted on the bus.
module tb_vdic_serial_rx;
  localparam int MAX_BYTES = 8;
  localparam int SIZE_W    = 4;
  localparam int W         = 8 + SIZE_W + 8*MAX_BYTES + 4;

  logic clk = 1'b0;
  logic rst_n;
  logic enable_n;
  logic din;
  logic busy;
  logic dbg_state;
`ifdef VDIC_RX_STATS_EN
  logic [15:0] stat_pkt_cnt;
  logic [7:0]  stat_err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  vdic_serial_rx_if #(.MAX_BYTES(MAX_BYTES), .SIZE_W(SIZE_W)) pkt_if ();

  vdic_serial_rx #(.MAX_BYTES(MAX_BYTES), .SIZE_W(SIZE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_n  (enable_n),
    .din       (din),
`ifdef VDIC_RX_STATS_EN
    .stat_pkt_cnt (stat_pkt_cnt),
    .stat_err_cnt (stat_err_cnt),
`endif
    .pkt       (pkt_if.master),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  function automatic logic [W-1:0] pack(input logic [7:0] cmd, input logic [SIZE_W-1:0] size,
                                        input logic [8*MAX_BYTES-1:0] data, input logic [3:0] err);
    return {cmd, size, data, err};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: compare on every accepted packet
  always @(negedge clk) begin
    if (rst_n === 1'b1 && pkt_if.pkt_valid === 1'b1 && pkt_if.pkt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pkt actual cmd=%0h err=%0h expected none", pkt_if.pkt_cmd, pkt_if.pkt_err);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("pkt_cmd",  pkt_if.pkt_cmd,  e[W-1 -: 8]);
        check("pkt_size", pkt_if.pkt_size, e[W-9 -: SIZE_W]);
        check("pkt_data", pkt_if.pkt_data, e[4 +: 8*MAX_BYTES]);
        check("pkt_err",  pkt_if.pkt_err,  e[3:0]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      enable_n = 1'b0;
      din      = w[9-i];
      tick();
    end
  endtask

  task automatic send_word(input logic flag, input logic [7:0] d, input logic flip);
    send_bits({flag, d, (^d) ^ flip}, 10);
  endtask

  task automatic idle_cycles(input int n);
    enable_n = 1'b1;
    din      = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, pkt_if.pkt_valid, 0);
    check({tag, "_cmd"},   pkt_if.pkt_cmd,   0);
    check({tag, "_size"},  pkt_if.pkt_size,  0);
    check({tag, "_data"},  pkt_if.pkt_data,  0);
    check({tag, "_err"},   pkt_if.pkt_err,   0);
    check({tag, "_busy"},  busy,             0);
  endtask

  initial begin
    rst_n = 1'b0;
    enable_n = 1'b1;
    din = 1'b0;
    pkt_if.pkt_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // 1: two data bytes and a command, enable_n continuous
    pkt_if.pkt_ready = 1'b1;
    exp_q.push_back(pack(8'h05, 4'd2, 64'h3412, 4'b0000));
    send_word(1'b0, 8'h12, 1'b0);
    send_word(1'b0, 8'h34, 1'b0);
    send_word(1'b1, 8'h05, 1'b0);
    idle_cycles(3);

    // 2: parity of the second data byte flipped
    exp_q.push_back(pack(8'h05, 4'd2, 64'h3412, 4'b0001));
    send_word(1'b0, 8'h12, 1'b0);
    send_word(1'b0, 8'h34, 1'b1);
    send_word(1'b1, 8'h05, 1'b0);
    idle_cycles(3);

    // 3: nine data bytes overflow the eight-byte buffer
    exp_q.push_back(pack(8'h03, 4'd8, 64'h0807060504030201, 4'b0010));
    for (int b = 1; b <= 9; b++) send_word(1'b0, 8'(b), 1'b0);
    send_word(1'b1, 8'h03, 1'b0);
    idle_cycles(3);

    // 4: enable_n released after the 4th bit of the second word
    exp_q.push_back(pack(8'h00, 4'd1, 64'h12, 4'b0100));
    send_word(1'b0, 8'h12, 1'b0);
    check("busy_mid_pkt", busy, 1);
    send_bits({1'b0, 8'h56, 1'b0}, 4);
    enable_n = 1'b1;
    din = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("busy_after_framing", busy, 0);
    idle_cycles(2);

    // 5: back-to-back packets while the consumer stalls
    pkt_if.pkt_ready = 1'b0;
    exp_q.push_back(pack(8'h33, 4'd0, 64'h0, 4'b1000));
    send_word(1'b0, 8'h11, 1'b0);
    send_word(1'b1, 8'h22, 1'b0);
    send_word(1'b1, 8'h33, 1'b0);
    idle_cycles(3);
    check("hold_valid", pkt_if.pkt_valid, 1);
    check("hold_cmd", pkt_if.pkt_cmd, 8'h33);
    pkt_if.pkt_ready = 1'b1;
    tick();
    pkt_if.pkt_ready = 1'b0;
    @(negedge clk);
    check("valid_after_accept", pkt_if.pkt_valid, 0);
    tick();

    // 6: reset mid data word, then a zero-byte packet
    pkt_if.pkt_ready = 1'b1;
    send_bits({1'b0, 8'h77, 1'b1}, 5);
    enable_n = 1'b1;
    din = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(pack(8'hA5, 4'd0, 64'h0, 4'b0000));
    send_word(1'b1, 8'hA5, 1'b0);
    idle_cycles(3);

    // drain
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("exp_q_drained", exp_q.size(), 0);
`ifdef VDIC_RX_STATS_EN
    check("stat_pkt_cnt", stat_pkt_cnt, 16'd1);
    check("stat_err_cnt", stat_err_cnt, 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vdic_serial_rx.md
Name: vdic_serial_rx

Overview:
- Serial input deserializer at the front of the VDIC DUT. Sits directly downstream of the serial stimulus driven on enable_n/din.
- Receives framed 10-bit words, checks parity and assembles data bytes plus a terminating command word into one parallel packet.
- Hands the packet to the DUT core over a valid/ready handshake.
- Reports parity, overflow, framing and overrun errors alongside the packet.

Parameters:
- MAX_BYTES, 8: maximum data bytes per packet. pkt_data width is 8*MAX_BYTES.
- SIZE_W, 4: width of pkt_size. Must hold MAX_BYTES.

Ports:
- clk  in  1  system clock; all inputs sampled on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable_n  in  1  low while a packet is being shifted in.
- din  in  1  serial data, MSB first.
- pkt_valid  out  1  packet available.
- pkt_ready  in  1  consumer accepts packet when pkt_valid && pkt_ready.
- pkt_cmd  out  8  command byte.
- pkt_size  out  SIZE_W  number of data bytes stored (0..MAX_BYTES).
- pkt_data  out  8*MAX_BYTES  byte i in bits [8i+7:8i]. Byte 0 is the first received.
- pkt_err  out  4  [0] parity, [1] overflow, [2] framing, [3] overrun.
- busy  out  1  high while a frame is in progress (state RX).

Behaviour:

Frame format:
- 10 bits: flag, d7..d0, parity.
- flag=0 marks a data word; flag=1 marks the command word that terminates the packet.
- Expected parity = XOR of d7..d0, for both flag values.

Reset (asynchronous):
- Outputs: pkt_valid=0, pkt_cmd=0, pkt_size=0, pkt_data=0, pkt_err=0, busy=0.
- Internal: state=IDLE, bit_cnt=0, byte_cnt=0, assembly errors cleared.
- Reset asserted mid-packet discards the partial packet with no output.

FSM:
- IDLE: wait for a sampled enable_n==0. On that cycle, capture din as bit 0 (the flag), set bit_cnt=1, go to RX.
- RX:
  - Shift din into a 10-bit shift register each cycle while enable_n==0.
  - When bit_cnt==9 (parity sampled), complete the word and set bit_cnt=0.
- RX with enable_n==1 and bit_cnt!=0:
  - Framing error. Emit a packet with cmd=0x00, size=byte_cnt, err[2]=1.
  - Go to IDLE.
- RX with enable_n==1 and bit_cnt==0 (between words, no command received yet):
  - Same framing-error emission, unless byte_cnt==0 and no bits were received. In that case return to IDLE silently.

Word completion:
- Parity mismatch sets assembly err[0]. The word is still used.
- Data word, byte_cnt<MAX_BYTES: store the byte at index byte_cnt, then byte_cnt+1.
- Data word, byte_cnt==MAX_BYTES: discard the byte, set err[1]. Size stays MAX_BYTES.
- Command word:
  - Load the output registers with cmd, size, data and errors. Unused data bytes read 0.
  - Set pkt_valid on the same rising edge that samples the command parity bit.
  - Clear assembly state.
  - If enable_n is still low, the next bit starts a new packet back-to-back (stay in RX, bit_cnt=0). Otherwise go to IDLE.

Handshake:
- pkt_valid and the output fields hold stable until pkt_valid && pkt_ready.
- pkt_valid drops on the edge after acceptance unless a new packet is loaded on that same edge. In that case pkt_valid stays 1 with the new contents.
- The serial input cannot be stalled. If a new packet completes while pkt_valid=1 and pkt_ready=0, the new packet overwrites the outputs with err[3]=1.
- pkt_ready while pkt_valid=0 is ignored.

Optional Feature:
VDIC_RX_STATS_EN:
- Defined: adds outputs stat_pkt_cnt [15:0] and stat_err_cnt [7:0].
  - stat_pkt_cnt increments on every packet emission.
  - stat_err_cnt increments on every emission with pkt_err!=0.
  - Both counters saturate and clear on reset.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
1. Data 0x12 (parity 0) and 0x34 (parity 1), then cmd 0x05 (parity 0), enable_n continuous -> one pkt_valid; cmd=0x05, size=2, data[15:0]=0x3412, err=0.
2. Same packet with the 0x34 parity bit flipped -> size=2, data unchanged, err=4'b0001.
3. Nine data bytes 0x01..0x09, then cmd 0x03 -> size=8, data=0x0807060504030201, err=4'b0010.
4. enable_n raised after the 4th bit of the second data word -> packet with cmd=0x00, size=1, err=4'b0100; busy=0 the next cycle.
5. Two back-to-back packets with pkt_ready held 0 -> the second overwrites the first with err=4'b1000; then pkt_ready=1 for one cycle -> pkt_valid=0 the following cycle.
6. rst_n pulsed low mid data word -> all outputs 0 immediately. A following valid packet (cmd 0xA5, 0 bytes) is received with size=0, err=0.
